// File: rtl/chaser_pkg.sv
// Shared types and defaults for the LED chaser program sequencer.
//   chaser_step_t  : one program entry {speed, dir, dwell}, MSB first
//   chaser_state_t : sequencer state (empty table, loaded and holding, running)
package chaser_pkg;

    localparam int unsigned CHASER_DEPTH   = 4;
    localparam int unsigned CHASER_DWELL_W = 2;

    typedef struct packed {
        logic [2:0]                speed;
        logic                      dir;
        logic [CHASER_DWELL_W-1:0] dwell;
    } chaser_step_t;

    localparam int unsigned CHASER_STEP_W = $bits(chaser_step_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2
    } chaser_state_t;

endpackage

// File: rtl/chaser_prog_table.sv
// Program table: DEPTH entries of chaser_step_t, synchronous write,
// synchronous clear/reset, two combinational read ports.
//   clk, reset_n       : clock, synchronous active-low reset
//   clear              : flush every entry to zero
//   wr_en/wr_idx/wr_data : write port
//   cur_idx/cur_data   : read port for the step being executed
//   nxt_idx/nxt_data   : read port for the step about to be presented
module chaser_prog_table
    import chaser_pkg::*;
#(
    parameter int unsigned DEPTH = CHASER_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH)-1:0]     wr_idx,
    input  logic [CHASER_STEP_W-1:0]     wr_data,
    input  logic [$clog2(DEPTH)-1:0]     cur_idx,
    output logic [CHASER_STEP_W-1:0]     cur_data,
    input  logic [$clog2(DEPTH)-1:0]     nxt_idx,
    output logic [CHASER_STEP_W-1:0]     nxt_data
);

    chaser_step_t mem [DEPTH];

    // Storage with reset/clear taking priority over the write port
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= chaser_step_t'(wr_data);
        end
    end

    assign cur_data = mem[cur_idx];
    assign nxt_data = mem[nxt_idx];

endmodule

// File: rtl/chaser_scheduler.sv
// Programmable sequencer for the LED chaser: appends steps to a small table
// and, while run is high, walks through them, each step lasting dwell+1 laps.
//   clk, reset_n : clock, synchronous active-low reset
//   wr_en/wr_data: append {speed, dir, dwell} to the table
//   clear        : flush the table (wins over everything else)
//   run          : level, 1 = sequence, 0 = hold current step
//   lap_tick     : one-cycle pulse per completed chaser lap
//   speed/direction : current step, zero while the table is empty
//   active       : sequencer is running
//   step_idx/count : current step index / number of loaded entries
//   wr_err       : one-cycle pulse after a dropped write
module chaser_scheduler
    import chaser_pkg::*;
#(
    parameter int unsigned DEPTH   = CHASER_DEPTH,
    parameter int unsigned DWELL_W = CHASER_DWELL_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [4+DWELL_W-1:0]       wr_data,
    input  logic                       clear,
    input  logic                       run,
    input  logic                       lap_tick,
    output logic [2:0]                 speed,
    output logic                       direction,
    output logic                       active,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       wr_err
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    chaser_state_t        state_q, state_d;
    logic [IW-1:0]        step_q, step_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 wr_ok, wr_err_d;
    logic [2:0]           speed_d;
    logic                 dir_d;

    logic [CHASER_STEP_W-1:0] cur_raw, nxt_raw;
    chaser_step_t             cur_step, nxt_step, out_step;

    chaser_prog_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .wr_en    (wr_ok),
        .wr_idx   (count_q[IW-1:0]),
        .wr_data  (wr_data),
        .cur_idx  (step_q),
        .cur_data (cur_raw),
        .nxt_idx  (step_d),
        .nxt_data (nxt_raw)
    );

    assign cur_step = chaser_step_t'(cur_raw);
    assign nxt_step = chaser_step_t'(nxt_raw);

    // Next-state, table pointer and dwell logic
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        count_d  = count_q;
        dwell_d  = dwell_q;
        wr_ok    = 1'b0;
        wr_err_d = 1'b0;

        if (clear) begin
            // A write colliding with clear is silently discarded
            state_d = ST_EMPTY;
            step_d  = '0;
            count_d = '0;
            dwell_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (wr_en) begin
                        wr_ok   = 1'b1;
                        count_d = count_q + CW'(1);
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (wr_en) begin
                        if (count_q == CW'(DEPTH)) begin
                            wr_err_d = 1'b1;
                        end else begin
                            wr_ok   = 1'b1;
                            count_d = count_q + CW'(1);
                        end
                    end
                    // Resume at the held step with a fresh dwell count
                    if (run) begin
                        state_d = ST_RUN;
                        dwell_d = '0;
                    end
                end
                ST_RUN: begin
                    if (wr_en) begin
                        wr_err_d = 1'b1;
                    end
                    // Dropping run freezes step and dwell, even on a tick
                    if (!run) begin
                        state_d = ST_READY;
                    end else if (lap_tick) begin
                        if (dwell_q == cur_step.dwell) begin
                            dwell_d = '0;
                            step_d  = (CW'(step_q) + CW'(1) == count_q) ? '0 : step_q + IW'(1);
                        end else begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // Bypass the entry being written so a first write shows up immediately
        if (wr_ok && (count_q[IW-1:0] == step_d)) begin
            out_step = chaser_step_t'(wr_data);
        end else begin
            out_step = nxt_step;
        end

        speed_d = '0;
        dir_d   = 1'b0;
        if (state_d != ST_EMPTY) begin
            speed_d = out_step.speed;
            dir_d   = out_step.dir;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_EMPTY;
            step_q    <= '0;
            count_q   <= '0;
            dwell_q   <= '0;
            speed     <= '0;
            direction <= 1'b0;
            active    <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            count_q   <= count_d;
            dwell_q   <= dwell_d;
            speed     <= speed_d;
            direction <= dir_d;
            active    <= (state_d == ST_RUN);
            wr_err    <= wr_err_d;
        end
    end

    assign step_idx = step_q;
    assign count    = count_q;

endmodule

// File: tb/tb_chaser_scheduler.sv
// Directed self-checking bench for chaser_scheduler (DEPTH=4, DWELL_W=2).
module tb_chaser_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_data = '0;
    logic       clear = 1'b0;
    logic       run = 1'b0;
    logic       lap_tick = 1'b0;
    logic [2:0] speed;
    logic       direction;
    logic       active;
    logic [1:0] step_idx;
    logic [2:0] count;
    logic       wr_err;

    int errors = 0;
    int checks = 0;

    chaser_scheduler #(
        .DEPTH   (4),
        .DWELL_W (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clear     (clear),
        .run       (run),
        .lap_tick  (lap_tick),
        .speed     (speed),
        .direction (direction),
        .active    (active),
        .step_idx  (step_idx),
        .count     (count),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check the full output set
    task automatic chk_all(input string tag, input int spd, input int dir, input int act,
                           input int idx, input int cnt, input int err);
        chk({tag, ".speed"},     32'(speed),     32'(spd));
        chk({tag, ".direction"}, 32'(direction), 32'(dir));
        chk({tag, ".active"},    32'(active),    32'(act));
        chk({tag, ".step_idx"},  32'(step_idx),  32'(idx));
        chk({tag, ".count"},     32'(count),     32'(cnt));
        chk({tag, ".wr_err"},    32'(wr_err),    32'(err));
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int s, input int d, input int w);
        wr_data = {3'(s), 1'(d), 2'(w)};
        wr_en   = 1'b1;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic lap();
        lap_tick = 1'b1;
        cyc();
        lap_tick = 1'b0;
    endtask

    initial begin
        // Reset then idle
        cyc();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        cyc();
        chk_all("idle", 0, 0, 0, 0, 0, 0);

        // Load three steps; first write is visible immediately
        wr(5, 1, 0);
        chk_all("load1", 5, 1, 0, 0, 1, 0);
        wr(2, 0, 1);
        chk_all("load2", 5, 1, 0, 0, 2, 0);
        wr(7, 1, 3);
        chk_all("load3", 5, 1, 0, 0, 3, 0);

        run = 1'b1;
        cyc();
        chk_all("run_on", 5, 1, 1, 0, 3, 0);
        lap();
        chk_all("s0_adv", 2, 0, 1, 1, 3, 0);
        lap();
        chk_all("s1_t1", 2, 0, 1, 1, 3, 0);
        lap();
        chk_all("s1_adv", 7, 1, 1, 2, 3, 0);
        lap(); lap(); lap();
        chk_all("s2_t3", 7, 1, 1, 2, 3, 0);
        lap();
        chk_all("s2_wrap", 5, 1, 1, 0, 3, 0);

        // Hold and resume at step 1
        lap();
        chk_all("to_s1", 2, 0, 1, 1, 3, 0);
        lap();
        chk("hold_pre.step_idx", 32'(step_idx), 32'd1);
        run = 1'b0;
        cyc();
        chk_all("hold", 2, 0, 0, 1, 3, 0);
        lap(); lap(); lap();
        chk_all("hold_ticks", 2, 0, 0, 1, 3, 0);
        run = 1'b1;
        cyc();
        chk_all("resume", 2, 0, 1, 1, 3, 0);
        lap();
        chk("resume_t1.step_idx", 32'(step_idx), 32'd1);
        lap();
        chk_all("resume_adv", 7, 1, 1, 2, 3, 0);

        // Run fall with tick at the final dwell lap: no advance
        lap(); lap(); lap();
        chk("pre_fall.step_idx", 32'(step_idx), 32'd2);
        run = 1'b0;
        lap();
        chk_all("fall_tick", 7, 1, 0, 2, 3, 0);
        // Run rise with tick: tick ignored, dwell restarts at 0
        run = 1'b1;
        lap();
        chk_all("rise_tick", 7, 1, 1, 2, 3, 0);
        lap(); lap(); lap();
        chk("rise_t3.step_idx", 32'(step_idx), 32'd2);
        lap();
        chk_all("rise_wrap", 5, 1, 1, 0, 3, 0);

        // Write during RUN is dropped
        wr(6, 0, 0);
        chk_all("run_wr", 5, 1, 1, 0, 3, 1);
        cyc();
        chk("run_wr_end.wr_err", 32'(wr_err), 32'd0);

        // Clear mid-RUN
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk_all("clr_run", 0, 0, 0, 0, 0, 0);
        run = 1'b0;
        cyc();

        // Overflow
        wr(1, 0, 0);
        wr(3, 1, 2);
        wr(4, 0, 1);
        wr(6, 1, 3);
        chk_all("full", 1, 0, 0, 0, 4, 0);
        wr(2, 1, 1);
        chk_all("ovf", 1, 0, 0, 0, 4, 1);
        cyc();
        chk_all("ovf_end", 1, 0, 0, 0, 4, 0);

        // Clear colliding with a write
        clear = 1'b1;
        wr(5, 1, 0);
        clear = 1'b0;
        chk_all("clr_wr", 0, 0, 0, 0, 0, 0);

        // Single entry, dwell 0
        wr(3, 1, 0);
        run = 1'b1;
        cyc();
        chk_all("one_run", 3, 1, 1, 0, 1, 0);
        lap();
        chk_all("one_t1", 3, 1, 1, 0, 1, 0);
        lap();
        chk_all("one_t2", 3, 1, 1, 0, 1, 0);
        lap();
        chk_all("one_t3", 3, 1, 1, 0, 1, 0);

        // Reset mid-RUN
        reset_n = 1'b0;
        cyc();
        chk_all("rst_run", 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        cyc();
        chk_all("post_rst", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
